// File: rtl/noc_output_arbiter.sv
// Output-port arbiter: round-robin grant among HEADER-eligible inputs, wormhole lock until TAIL, credit gating.
// Zero-latency grant/sel/valid_out (combinational pop); lock, owner and credit state registered.
module noc_output_arbiter #(
  parameter int          CREDITS = 4,
  parameter int          CW      = 3,
  parameter logic [2:0]  HEADER  = 3'b001,
  parameter logic [2:0]  PAYLOAD = 3'b010,
  parameter logic [2:0]  TAIL    = 3'b100
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    req,
  input  logic [14:0]   flit_id_in,
  input  logic          credit_in,
  output logic [4:0]    grant,
  output logic          valid_out,
  output logic [2:0]    sel,
  output logic          locked,
  output logic [2:0]    owner,
  output logic [CW-1:0] credits,
  output logic          credit_err
);

  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [2:0]    owner_q, owner_d;
  logic [2:0]    last_q, last_d;
  logic [CW-1:0] credits_q;
  logic          credit_err_q;

  logic [2:0] fid [5];
  logic [4:0] elig;
  logic [4:0] grant_c;
  logic [2:0] sel_c;
  logic [2:0] cand;
  logic [3:0] sum;
  logic       found;
  logic       send;

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      fid[i]  = flit_id_in[3*i +: 3];
      elig[i] = req[i] && (fid[i] == HEADER);
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_c = '0;
    sel_c   = '0;
    cand    = '0;
    sum     = '0;
    found   = 1'b0;
    case (state_q)
      IDLE: begin
        if (credits_q != '0) begin
          // Search starts one past the last owner so the previous winner goes last.
          for (int k = 1; k <= 5; k++) begin
            sum  = {1'b0, last_q} + 4'(k);
            cand = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
            if (!found && elig[cand]) begin
              found   = 1'b1;
              sel_c   = cand;
              grant_c = 5'b00001 << cand;
            end
          end
          if (found) begin
            state_d = LOCKED;
            owner_d = sel_c;
          end
        end
      end
      LOCKED: begin
        if (req[owner_q] && (credits_q != '0) &&
            (fid[owner_q] == PAYLOAD || fid[owner_q] == TAIL)) begin
          grant_c = 5'b00001 << owner_q;
          sel_c   = owner_q;
          if (fid[owner_q] == TAIL) begin
            state_d = IDLE;
            last_d  = owner_q;
            owner_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      grant_c = '0;
      sel_c   = '0;
    end
  end

  assign send = |grant_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_q       <= 3'd4;
      credits_q    <= CRED_MAX;
      credit_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      case ({send, credit_in})
        2'b10: credits_q <= credits_q - 1'b1;
        2'b01: begin
          if (credits_q == CRED_MAX) credit_err_q <= 1'b1;
          else                       credits_q    <= credits_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign grant      = grant_c;
  assign valid_out  = send;
  assign sel        = sel_c;
  assign locked     = (state_q == LOCKED);
  assign owner      = owner_q;
  assign credits    = credits_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_noc_output_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req;
  logic [14:0] flit_id_in;
  logic        credit_in;
  logic [4:0]  grant;
  logic        valid_out;
  logic [2:0]  sel;
  logic        locked;
  logic [2:0]  owner;
  logic [2:0]  credits;
  logic        credit_err;

  localparam logic [2:0] Z = 3'b000, H = 3'b001, P = 3'b010, T = 3'b100;

  noc_output_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .flit_id_in(flit_id_in), .credit_in(credit_in),
    .grant(grant), .valid_out(valid_out), .sel(sel), .locked(locked), .owner(owner),
    .credits(credits), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] grant;
    logic [2:0] sel;
    logic       valid;
    logic       locked;
    logic [2:0] owner;
    logic [2:0] credits;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic logic [14:0] f(input logic [2:0] a0, a1, a2, a3, a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  task automatic step(input string name, input logic r, input logic [4:0] rq,
                      input logic [14:0] fi, input logic ci,
                      input logic [4:0] eg, input logic el, input logic [2:0] eo,
                      input logic [2:0] ec, input logic ee);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; req = rq; flit_id_in = fi; credit_in = ci;
    e.name = name; e.grant = eg; e.valid = |eg; e.locked = el;
    e.owner = eo; e.credits = ec; e.err = ee; e.sel = 3'd0;
    for (int i = 0; i < 5; i++) if (eg[i]) e.sel = 3'(i);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if ({grant, sel, valid_out, locked, owner, credits, credit_err} !==
          {e.grant, e.sel, e.valid, e.locked, e.owner, e.credits, e.err}) begin
        n_fail++;
        $display("FAIL %s: got grant=%b sel=%0d vld=%b lck=%b own=%0d cr=%0d err=%b, want grant=%b sel=%0d vld=%b lck=%b own=%0d cr=%0d err=%b",
                 e.name, grant, sel, valid_out, locked, owner, credits, credit_err,
                 e.grant, e.sel, e.valid, e.locked, e.owner, e.credits, e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req = '0; flit_id_in = '0; credit_in = 1'b0;
    repeat (2) @(posedge clk);

    // reset holds grant low even with every input requesting a header
    step("rst_hold0", 1, 5'b11111, f(H,H,H,H,H), 0, 5'b00000, 0, 0, 4, 0);
    step("rst_hold1", 1, 5'b11111, f(H,H,H,H,H), 0, 5'b00000, 0, 0, 4, 0);
    step("idle",      0, 5'b00000, f(Z,Z,Z,Z,Z), 0, 5'b00000, 0, 0, 4, 0);

    // single 3-flit packet from N
    step("n_hdr",  0, 5'b00010, f(Z,H,Z,Z,Z), 0, 5'b00010, 0, 0, 4, 0);
    step("n_pay",  0, 5'b00010, f(Z,P,Z,Z,Z), 0, 5'b00010, 1, 1, 3, 0);
    step("n_tail", 0, 5'b00010, f(Z,T,Z,Z,Z), 0, 5'b00010, 1, 1, 2, 0);
    step("n_done", 0, 5'b00000, f(Z,Z,Z,Z,Z), 0, 5'b00000, 0, 0, 1, 0);
    step("cr_ret1", 0, 5'b00000, f(Z,Z,Z,Z,Z), 1, 5'b00000, 0, 0, 1, 0);
    step("cr_ret2", 0, 5'b00000, f(Z,Z,Z,Z,Z), 1, 5'b00000, 0, 0, 2, 0);
    step("cr_ret3", 0, 5'b00000, f(Z,Z,Z,Z,Z), 1, 5'b00000, 0, 0, 3, 0);
    step("rst2",    1, 5'b00000, f(Z,Z,Z,Z,Z), 0, 5'b00000, 0, 0, 4, 0);

    // L vs E contention after reset: L first, E next, then L again
    step("le_hdr",   0, 5'b00101, f(H,Z,H,Z,Z), 0, 5'b00001, 0, 0, 4, 0);
    step("l_pay",    0, 5'b00101, f(P,Z,H,Z,Z), 1, 5'b00001, 1, 0, 3, 0);
    step("l_tail",   0, 5'b00101, f(T,Z,H,Z,Z), 1, 5'b00001, 1, 0, 3, 0);
    step("e_hdr",    0, 5'b00100, f(Z,Z,H,Z,Z), 0, 5'b00100, 0, 0, 3, 0);
    step("e_pay_ci", 0, 5'b00100, f(Z,Z,P,Z,Z), 1, 5'b00100, 1, 2, 2, 0);
    step("e_tail",   0, 5'b00101, f(H,Z,T,Z,Z), 1, 5'b00100, 1, 2, 2, 0);
    step("le_hdr2",  0, 5'b00101, f(H,Z,H,Z,Z), 0, 5'b00001, 0, 0, 2, 0);
    step("l_tail2",  0, 5'b00101, f(T,Z,H,Z,Z), 0, 5'b00001, 1, 0, 1, 0);
    step("e_nocred", 0, 5'b00100, f(Z,Z,H,Z,Z), 1, 5'b00000, 0, 0, 0, 0);
    step("e_hdr2",   0, 5'b00100, f(Z,Z,H,Z,Z), 0, 5'b00100, 0, 0, 1, 0);

    // mid-packet stalls: no credits, no request, owner header while locked
    step("stall_cr0", 0, 5'b00100, f(Z,Z,P,Z,Z), 0, 5'b00000, 1, 2, 0, 0);
    step("stall_cr1", 0, 5'b00100, f(Z,Z,P,Z,Z), 1, 5'b00000, 1, 2, 0, 0);
    step("cr_resume", 0, 5'b00100, f(Z,Z,P,Z,Z), 0, 5'b00100, 1, 2, 1, 0);
    step("stall_req", 0, 5'b00000, f(Z,Z,Z,Z,Z), 1, 5'b00000, 1, 2, 0, 0);
    step("own_hdr",   0, 5'b00100, f(Z,Z,H,Z,Z), 1, 5'b00000, 1, 2, 1, 0);
    step("e_tail2",   0, 5'b00100, f(Z,Z,T,Z,Z), 1, 5'b00100, 1, 2, 2, 0);
    step("cr_up3",    0, 5'b00000, f(Z,Z,Z,Z,Z), 1, 5'b00000, 0, 0, 2, 0);
    step("cr_up4",    0, 5'b00000, f(Z,Z,Z,Z,Z), 1, 5'b00000, 0, 0, 3, 0);
    step("cr_ovf",    0, 5'b00000, f(Z,Z,Z,Z,Z), 1, 5'b00000, 0, 0, 4, 0);
    step("err_set",   0, 5'b00000, f(Z,Z,Z,Z,Z), 1, 5'b00000, 0, 0, 4, 1);
    step("err_stick", 0, 5'b00000, f(Z,Z,Z,Z,Z), 0, 5'b00000, 0, 0, 4, 1);

    // reset in the middle of a W packet
    step("w_hdr",     0, 5'b01000, f(Z,Z,Z,H,Z), 0, 5'b01000, 0, 0, 4, 1);
    step("w_rst",     1, 5'b01000, f(Z,Z,Z,P,Z), 0, 5'b00000, 1, 3, 3, 1);
    step("w_pay_ign", 0, 5'b11000, f(Z,Z,Z,P,T), 0, 5'b00000, 0, 0, 4, 0);
    step("w_hdr2",    0, 5'b01000, f(Z,Z,Z,H,Z), 0, 5'b01000, 0, 0, 4, 0);
    step("w_locked",  0, 5'b00000, f(Z,Z,Z,Z,Z), 0, 5'b00000, 1, 3, 3, 0);

    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
